// File: rtl/board_ram_arbiter_pkg.sv
// Shared definitions for the board RAM arbiter.
//   - Board geometry (10 x 24 playfield, addr = y*10 + x) and RAM widths.
//   - Requester port indices and the arbiter state encoding.
//   - Small helpers for port-index arithmetic.
package board_ram_arbiter_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 6;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 24;

    localparam logic [1:0] PORT_COMMIT = 2'd0;
    localparam logic [1:0] PORT_CLEAR  = 2'd1;
    localparam logic [1:0] PORT_READ   = 2'd2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Port that follows p in round-robin order, wrapping 2 -> 0.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        case (p)
            PORT_COMMIT: next_port = PORT_CLEAR;
            PORT_CLEAR:  next_port = PORT_READ;
            default:     next_port = PORT_COMMIT;
        endcase
    endfunction

    // Index of a one-hot 3-bit vector (zero for anything not one-hot).
    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        case (oh)
            3'b010:  onehot_idx = PORT_CLEAR;
            3'b100:  onehot_idx = PORT_READ;
            default: onehot_idx = PORT_COMMIT;
        endcase
    endfunction

endpackage

// File: rtl/board_ram_arbiter_rr_pick3.sv
// Combinational 3-way pick: first set request bit searching upward from
// ptr_i, wrapping 2 -> 0.
//   req_i   [2:0]  request vector
//   ptr_i   [1:0]  starting port (3 is treated as 0)
//   pick_o  [2:0]  one-hot winner (zero when no request)
//   valid_o        at least one request present
module board_ram_arbiter_rr_pick3 (
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] pick_o,
    output logic       valid_o
);

    // Priority search rotated by the pointer.
    always_comb begin
        pick_o  = 3'b000;
        valid_o = |req_i;
        case (ptr_i)
            2'd1: begin
                if (req_i[1])      pick_o = 3'b010;
                else if (req_i[2]) pick_o = 3'b100;
                else if (req_i[0]) pick_o = 3'b001;
                else               pick_o = 3'b000;
            end
            2'd2: begin
                if (req_i[2])      pick_o = 3'b100;
                else if (req_i[0]) pick_o = 3'b001;
                else if (req_i[1]) pick_o = 3'b010;
                else               pick_o = 3'b000;
            end
            default: begin
                if (req_i[0])      pick_o = 3'b001;
                else if (req_i[1]) pick_o = 3'b010;
                else if (req_i[2]) pick_o = 3'b100;
                else               pick_o = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Single-port board RAM arbiter for three requesters:
//   port 0 piece-commit writer, port 1 line-clear engine, port 2 render reader.
// Registered round-robin grant held for a burst (bounded by MAX_BURST issues),
// one dead cycle between grants, and a tagged RD_LAT-deep ack pipeline so
// each access (read or write) is acked to the port that issued it.
// Optional macro ARB_FIXED_PRIO_EN: fixed priority 0 > 1 > 2 instead of
// round-robin (MAX_BURST release still applies).
// Ports:
//   clk, resetn                 clock, async active-low reset
//   req/we [2:0]                per-port request (held for burst) / write enable
//   addr0..2, wdata0..2         per-port address / write data
//   gnt [2:0]                   registered one-hot grant
//   ack [2:0], rdata            per-port ack pulse, RAM q forwarded
//   ram_addr/ram_wren/ram_wdata RAM command (addr holds when idle)
//   ram_q                       RAM read data
//   busy                        granted or any access in flight
module board_ram_arbiter
    import board_ram_arbiter_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        gnt,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_e        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] wdata_hold_q;
    logic [2:0]        ack_pipe_q [RD_LAT];

    logic [1:0]        pick_ptr_s;
    logic [2:0]        pick_s;
    logic              pick_valid_s;
    logic              issue_s;
    logic              own_we_s;
    logic [ADDR_W-1:0] own_addr_s;
    logic [DATA_W-1:0] own_wdata_s;
    logic              inflight_s;

`ifdef ARB_FIXED_PRIO_EN
    assign pick_ptr_s = 2'd0;
`else
    assign pick_ptr_s = rr_ptr_q;
`endif

    board_ram_arbiter_rr_pick3 u_pick (
        .req_i   (req),
        .ptr_i   (pick_ptr_s),
        .pick_o  (pick_s),
        .valid_o (pick_valid_s)
    );

    // gnt_q is only non-zero in GRANT, so this is "owner requests this cycle".
    assign issue_s = |(gnt_q & req);

    // Select the owner's command fields.
    always_comb begin
        own_we_s    = 1'b0;
        own_addr_s  = {ADDR_W{1'b0}};
        own_wdata_s = {DATA_W{1'b0}};
        case (owner_q)
            PORT_COMMIT: begin
                own_we_s = we[0]; own_addr_s = addr0; own_wdata_s = wdata0;
            end
            PORT_CLEAR: begin
                own_we_s = we[1]; own_addr_s = addr1; own_wdata_s = wdata1;
            end
            PORT_READ: begin
                own_we_s = we[2]; own_addr_s = addr2; own_wdata_s = wdata2;
            end
            default: begin
                own_we_s = 1'b0;
            end
        endcase
    end

    // RAM command: live from the owner when issuing, otherwise hold the last one.
    always_comb begin
        if (issue_s) begin
            ram_addr  = own_addr_s;
            ram_wdata = own_wdata_s;
            ram_wren  = own_we_s;
        end else begin
            ram_addr  = addr_hold_q;
            ram_wdata = wdata_hold_q;
            ram_wren  = 1'b0;
        end
    end

    // Next-state logic: arbitrate in IDLE, count and release bursts in GRANT.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_d     = ARB_GRANT;
                    owner_d     = onehot_idx(pick_s);
                    gnt_d       = pick_s;
                    burst_cnt_d = 8'd0;
                end else begin
                    gnt_d = 3'b000;
                end
            end
            ARB_GRANT: begin
                // Dropped request or the last allowed issue ends the burst.
                if (!issue_s || (burst_cnt_q == BURST_LAST)) begin
                    state_d     = ARB_IDLE;
                    gnt_d       = 3'b000;
                    rr_ptr_d    = next_port(owner_q);
                    burst_cnt_d = 8'd0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                gnt_d       = 3'b000;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ARB_IDLE;
            owner_q     <= 2'd0;
            rr_ptr_q    <= 2'd0;
            gnt_q       <= 3'b000;
            burst_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Last issued address/data, driven to the RAM while idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_hold_q  <= {ADDR_W{1'b0}};
            wdata_hold_q <= {DATA_W{1'b0}};
        end else if (issue_s) begin
            addr_hold_q  <= own_addr_s;
            wdata_hold_q <= own_wdata_s;
        end else begin
            addr_hold_q  <= addr_hold_q;
            wdata_hold_q <= wdata_hold_q;
        end
    end

    // Ack pipeline: the one-hot grant doubles as the owner tag of each issue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LAT; i++) ack_pipe_q[i] <= 3'b000;
        end else begin
            ack_pipe_q[0] <= issue_s ? gnt_q : 3'b000;
            for (int i = 1; i < RD_LAT; i++) ack_pipe_q[i] <= ack_pipe_q[i-1];
        end
    end

    // Any access still travelling through the pipeline.
    always_comb begin
        inflight_s = 1'b0;
        for (int i = 0; i < RD_LAT; i++) inflight_s = inflight_s | (|ack_pipe_q[i]);
    end

    assign gnt   = gnt_q;
    assign ack   = ack_pipe_q[RD_LAT-1];
    assign rdata = ram_q;
    assign busy  = (state_q == ARB_GRANT) | inflight_s;

endmodule
